// File: rtl/br_update_unit.sv
// br_update_unit: branch resolution, fetch redirect, agree-BTB write and PHT/GHR update.
// Resolutions are registered for one cycle and committed to the BTB, PHT, GHR and statistics counters.
module br_update_unit #(
    parameter int INDEX_WIDTH = 6,
    parameter int PHT_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             if_pc_i,
    output logic [PHT_WIDTH-1:0]    if_pht_index_o,
    output logic                    if_agree_o,
    input  logic                    ex_valid_i,
    input  logic                    ex_is_branch_i,
    input  logic                    ex_is_jump_i,
    input  logic [31:0]             ex_pc_i,
    input  logic [31:0]             ex_target_i,
    input  logic                    ex_taken_i,
    input  logic                    ex_pred_taken_i,
    input  logic [31:0]             ex_pred_target_i,
    input  logic                    ex_btb_hit_i,
    input  logic                    ex_bias_i,
    input  logic [PHT_WIDTH-1:0]    ex_pht_index_i,
    output logic                    redirect_o,
    output logic [31:0]             redirect_pc_o,
    output logic                    btb_wren_o,
    output logic [INDEX_WIDTH-1:0]  btb_wr_index_o,
    output logic [29-INDEX_WIDTH:0] btb_wr_tag_o,
    output logic [31:0]             btb_wr_target_o,
    output logic                    btb_br_taken_o,
    output logic [31:0]             branch_count_o,
    output logic [31:0]             mispredict_count_o
);
    localparam int PHT_DEPTH = 2 ** PHT_WIDTH;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          target;
        logic                 taken;
        logic                 hit;
        logic                 bias;
        logic [PHT_WIDTH-1:0] pht_index;
        logic                 is_branch;
        logic                 alloc;
        logic                 wr;
        logic                 mis;
    } upd_t;

    logic                 res, mis, alloc, retarget, agree, br_commit;
    logic [1:0]           cnt;
    logic [1:0]           pht_q [PHT_DEPTH];
    logic [1:0]           pht_d [PHT_DEPTH];
    logic [PHT_WIDTH-1:0] ghr_q, ghr_d;
    upd_t                 upd_q, upd_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [31:0]          branch_count_q, branch_count_d;
    logic [31:0]          mispredict_count_q, mispredict_count_d;
    logic                 unused_bits;

    assign unused_bits = ^{if_pc_i[31:PHT_WIDTH+2], if_pc_i[1:0], upd_q.pc[1:0]};

    // Fetch lookup reads the committed state only, so a same-cycle write is not bypassed.
    assign if_pht_index_o = if_pc_i[PHT_WIDTH+1:2] ^ ghr_q;
    assign if_agree_o     = pht_q[if_pht_index_o][1];

    always_comb begin
        res           = ex_valid_i & (ex_is_branch_i | ex_is_jump_i);
        mis           = res & ((ex_taken_i != ex_pred_taken_i) |
                               (ex_taken_i & (ex_pred_target_i != ex_target_i)));
        alloc         = ex_taken_i & !ex_btb_hit_i;
        retarget      = ex_taken_i & ex_btb_hit_i & (ex_pred_target_i != ex_target_i);
        redirect_o    = mis;
        redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        upd_valid_d   = res;
        upd_d         = res ? '{pc: ex_pc_i, target: ex_target_i, taken: ex_taken_i,
                                hit: ex_btb_hit_i, bias: ex_bias_i, pht_index: ex_pht_index_i,
                                is_branch: ex_is_branch_i, alloc: alloc,
                                wr: alloc | retarget, mis: mis} : upd_q;
        // A BTB miss allocates with bias equal to the outcome, so it always agrees.
        agree         = upd_q.hit ? (upd_q.taken == upd_q.bias) : 1'b1;
        br_commit     = upd_valid_q & upd_q.is_branch;
        cnt           = pht_q[upd_q.pht_index];
        pht_d         = pht_q;
        if (br_commit)
            pht_d[upd_q.pht_index] = agree ? ((cnt == 2'd3) ? cnt : cnt + 2'd1)
                                           : ((cnt == 2'd0) ? cnt : cnt - 2'd1);
        ghr_d              = br_commit ? {ghr_q[PHT_WIDTH-2:0], upd_q.taken} : ghr_q;
        branch_count_d     = branch_count_q + 32'(upd_valid_q);
        mispredict_count_d = mispredict_count_q + 32'(upd_valid_q & upd_q.mis);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pht_q              <= '{default: 2'b10};
            ghr_q              <= '0;
            upd_q              <= '0;
            upd_valid_q        <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            pht_q              <= pht_d;
            ghr_q              <= ghr_d;
            upd_q              <= upd_d;
            upd_valid_q        <= upd_valid_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // A retarget keeps the existing bias; only a fresh allocation forces it to taken.
    assign btb_wren_o         = upd_valid_q & upd_q.wr;
    assign btb_wr_index_o     = upd_q.pc[INDEX_WIDTH+1:2];
    assign btb_wr_tag_o       = upd_q.pc[31:INDEX_WIDTH+2];
    assign btb_wr_target_o    = upd_q.target;
    assign btb_br_taken_o     = upd_q.alloc ? 1'b1 : upd_q.bias;
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;
endmodule

// File: tb/tb_br_update_unit.sv
// tb_br_update_unit: directed bench for br_update_unit with a BTB-write scoreboard
// and a reference model of the PHT, GHR and statistics counters.
module tb_br_update_unit;
    logic        clk_i, rst_ni;
    logic [31:0] if_pc_i;
    logic [7:0]  if_pht_index_o;
    logic        if_agree_o;
    logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
    logic        ex_taken_i, ex_pred_taken_i, ex_btb_hit_i, ex_bias_i;
    logic [7:0]  ex_pht_index_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        btb_wren_o;
    logic [5:0]  btb_wr_index_o;
    logic [23:0] btb_wr_tag_o;
    logic [31:0] btb_wr_target_o;
    logic        btb_br_taken_o;
    logic [31:0] branch_count_o, mispredict_count_o;

    br_update_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .if_pc_i(if_pc_i),
        .if_pht_index_o(if_pht_index_o), .if_agree_o(if_agree_o),
        .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .ex_is_jump_i(ex_is_jump_i),
        .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_taken_i(ex_taken_i),
        .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
        .ex_btb_hit_i(ex_btb_hit_i), .ex_bias_i(ex_bias_i), .ex_pht_index_i(ex_pht_index_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .btb_wren_o(btb_wren_o), .btb_wr_index_o(btb_wr_index_o), .btb_wr_tag_o(btb_wr_tag_o),
        .btb_wr_target_o(btb_wr_target_o), .btb_br_taken_o(btb_br_taken_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    typedef struct packed {
        logic [5:0]  idx;
        logic [23:0] tag;
        logic [31:0] tgt;
        logic        bias;
    } btb_t;

    btb_t        exp_q[$];
    logic [1:0]  m_pht [256];
    logic [7:0]  m_ghr, ghr_old;
    logic [31:0] m_cnt, m_mis;
    int          checks = 0;
    int          errors = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every BTB write pulse must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni && btb_wren_o) begin
            if (exp_q.size() == 0) chk("btb_unexpected_write", 64'(btb_wren_o), 64'd0);
            else begin
                btb_t e;
                e = exp_q.pop_front();
                chk("btb_write", {btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, btb_br_taken_o}, e);
            end
        end
    end

    task automatic model_reset();
        foreach (m_pht[i]) m_pht[i] = 2'b10;
        m_ghr = '0; ghr_old = '0; m_cnt = '0; m_mis = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; ex_valid_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic step(input logic br, input logic jmp, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic pt, input logic [31:0] ptgt,
                        input logic hit, input logic bs, input logic [7:0] pidx);
        logic m, al, rt, agr;
        @(negedge clk_i);
        ex_valid_i = 1'b1; ex_is_branch_i = br; ex_is_jump_i = jmp; ex_pc_i = pc;
        ex_target_i = tgt; ex_taken_i = tk; ex_pred_taken_i = pt; ex_pred_target_i = ptgt;
        ex_btb_hit_i = hit; ex_bias_i = bs; ex_pht_index_i = pidx;
        m  = (tk != pt) | (tk & (ptgt != tgt));
        al = tk & !hit;
        rt = tk & hit & (ptgt != tgt);
        #1;
        chk("redirect", 64'(redirect_o), 64'(m));
        chk("redirect_pc", 64'(redirect_pc_o), 64'(tk ? tgt : pc + 32'd4));
        if (al | rt) exp_q.push_back(btb_t'{pc[7:2], pc[31:8], tgt, al ? 1'b1 : bs});
        m_cnt++;
        if (m) m_mis++;
        ghr_old = m_ghr;
        if (br) begin
            agr = hit ? (tk == bs) : 1'b1;
            if (agr && m_pht[pidx] != 2'd3) m_pht[pidx]++;
            if (!agr && m_pht[pidx] != 2'd0) m_pht[pidx]--;
            m_ghr = {m_ghr[6:0], tk};
        end
    endtask

    task automatic check_state(input logic [7:0] pidx);
        @(negedge clk_i);
        ex_valid_i = 1'b0; if_pc_i = '0;
        #1 chk("ghr_before_commit", 64'(if_pht_index_o), 64'(ghr_old));
        @(negedge clk_i);
        #1;
        chk("ghr", 64'(if_pht_index_o), 64'(m_ghr));
        chk("pht_counter", 64'(dut.pht_q[pidx]), 64'(m_pht[pidx]));
        chk("branch_count", 64'(branch_count_o), 64'(m_cnt));
        chk("mispredict_count", 64'(mispredict_count_o), 64'(m_mis));
        chk("btb_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0; if_pc_i = '0;
        ex_valid_i = 0; ex_is_branch_i = 0; ex_is_jump_i = 0; ex_pc_i = '0; ex_target_i = '0;
        ex_taken_i = 0; ex_pred_taken_i = 0; ex_pred_target_i = '0; ex_btb_hit_i = 0;
        ex_bias_i = 0; ex_pht_index_i = '0;
        model_reset();
        do_reset();
        // Reset state: weakly-agree PHT, empty GHR, idle BTB port, zero counters.
        for (int i = 0; i < 3; i++) begin
            if_pc_i = 32'h1234_5670 + 32'(i * 'h94);
            #1;
            chk("reset_agree", 64'(if_agree_o), 64'd1);
            chk("reset_index", 64'(if_pht_index_o), 64'(if_pc_i[9:2]));
        end
        chk("reset_wren", 64'(btb_wren_o), 64'd0);
        chk("reset_branch_count", 64'(branch_count_o), 64'd0);
        chk("reset_mispredict_count", 64'(mispredict_count_o), 64'd0);
        // Taken branch missing in the BTB: allocate, counter 2->3.
        step(1, 0, 32'h100, 32'h80, 1, 0, 32'h0, 0, 0, 8'h40);
        check_state(8'h40);
        // Not-taken branch disagreeing with bias: decrement twice to saturate at 0.
        step(1, 0, 32'h200, 32'h300, 0, 1, 32'h300, 1, 1, 8'h81);
        check_state(8'h81);
        step(1, 0, 32'h200, 32'h300, 0, 1, 32'h300, 1, 1, 8'h81);
        check_state(8'h81);
        if_pc_i = {22'd0, 8'h81 ^ m_ghr, 2'b00};
        #1 chk("agree_after_saturate", 64'(if_agree_o), 64'd0);
        // JAL retarget keeps the stored bias; PHT and GHR untouched.
        step(0, 1, 32'h300, 32'h500, 1, 1, 32'h400, 1, 0, 8'h81);
        check_state(8'h81);
        // Four back-to-back correctly predicted taken branches.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h1000 + 32'(i * 4), 32'h2000, 1, 1, 32'h2000, 1, 1, 8'(i));
        check_state(8'h03);
        chk("btb_b2b_ghr", 64'(if_pht_index_o), 64'h0f);
        chk("pht_b2b_first", 64'(dut.pht_q[0]), 64'd3);
        // Reset during the update cycle discards the pending BTB write.
        step(1, 0, 32'h600, 32'h700, 1, 0, 32'h0, 0, 0, 8'h22);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0; ex_valid_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #1 chk("wren_after_reset", 64'(btb_wren_o), 64'd0);
        end
        if_pc_i = '0;
        #1;
        chk("pht_after_reset", 64'(dut.pht_q[8'h22]), 64'd2);
        chk("ghr_after_reset", 64'(if_pht_index_o), 64'd0);
        chk("branch_count_after_reset", 64'(branch_count_o), 64'd0);
        chk("mispredict_count_after_reset", 64'(mispredict_count_o), 64'd0);
        chk("btb_queue_final", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
